// File: rtl/mips_regs_pkg.sv
// Shared MIPS register-file definitions used by the write-back queue and the
// register file integration.
package mips_regs_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_ZERO  = 0;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // One pending register-file write: destination index plus value.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of write-back requests. Besides the head it exposes every
// entry ordered by age (index 0 = oldest) so the owner can search pending data.
module wb_fifo
    import mips_regs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  wb_req_t                    wr_req_i,
    output wb_req_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DEPTH-1:0]           age_valid_o,
    output wb_req_t [DEPTH-1:0]        age_req_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    // Next pointers/count; pointers wrap naturally, fullness comes from count.
    always_comb begin
        push_ok  = push_i && !flush_i;
        pop_ok   = pop_i && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because validity comes from count.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= wr_req_i;
    end

    // Age-ordered view of the entries for the bypass search.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx            = rd_ptr_q + PTR_W'(i);
            age_req_o[i]   = mem_q[idx];
            age_valid_o[i] = (CNT_W'(i) < count_q);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back initiator for the 32-entry GPR file: queues (dest, data) writes,
// drains one per cycle to the register file port, tracks pending writes per
// register and offers two bypass lookups over not-yet-committed data.
//
// Handshake: a request transfers at a posedge where in_valid && in_ready.
// in_ready depends only on reset and occupancy (never on in_valid), and a full
// queue refuses even if a pop happens in the same cycle. A transferred request
// with in_dest == 0 is consumed but discarded.
module regfile_wb_queue
    import mips_regs_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain_en,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_write_register,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regwrite,
    output logic [31:0]       busy,
    input  logic [ADDR_W-1:0] byp_addr_1,
    input  logic [ADDR_W-1:0] byp_addr_2,
    output logic              byp_hit_1,
    output logic              byp_hit_2,
    output logic [DATA_W-1:0] byp_data_1,
    output logic [DATA_W-1:0] byp_data_2
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int SB_W  = $clog2(DEPTH+2);

    logic [CNT_W-1:0]    fifo_count;
    wb_req_t             fifo_head;
    logic [DEPTH-1:0]    age_valid;
    wb_req_t [DEPTH-1:0] age_req;
    wb_req_t             wr_req;
    logic                push;
    logic                pop;

    logic                stage_valid_q;
    wb_req_t             stage_req_q;
    logic [SB_W-1:0]     sb_cnt_q [NUM_REGS];
    logic [SB_W-1:0]     sb_cnt_d [NUM_REGS];
    logic [31:0]         busy_q, busy_d;

    assign in_ready = !reset && (fifo_count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush && (in_dest != ADDR_W'(REG_ZERO));
    assign pop      = (fifo_count != '0) && drain_en && !flush;
    assign wr_req   = '{dest: in_dest, data: in_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .wr_req_i    (wr_req),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .age_valid_o (age_valid),
        .age_req_o   (age_req)
    );

    // Output stage: load the head on a pop, otherwise drop the strobe and hold.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stage_valid_q <= 1'b0;
            stage_req_q   <= '0;
        end else if (pop) begin
            stage_valid_q <= 1'b1;
            stage_req_q   <= fifo_head;
        end else begin
            stage_valid_q <= 1'b0;
        end
    end

    // Per-register pending counts: +1 on a kept push, -1 as the staged write retires.
    always_comb begin
        sb_cnt_d = sb_cnt_q;
        busy_d   = '0;
        if (flush) begin
            sb_cnt_d = '{default: '0};
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (push && in_dest == ADDR_W'(r))
                    sb_cnt_d[r] = sb_cnt_d[r] + SB_W'(1);
                if (stage_valid_q && stage_req_q.dest == ADDR_W'(r))
                    sb_cnt_d[r] = sb_cnt_d[r] - SB_W'(1);
                busy_d[r] = (sb_cnt_d[r] != '0);
            end
        end
    end

    // Scoreboard and registered busy vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_cnt_q <= '{default: '0};
            busy_q   <= '0;
        end else begin
            sb_cnt_q <= sb_cnt_d;
            busy_q   <= busy_d;
        end
    end

    // Bypass search: staged write is oldest, then FIFO entries oldest to newest,
    // so the last match found is the newest pending value.
    always_comb begin
        logic [ADDR_W-1:0] addr [2];
        logic              hit  [2];
        logic [DATA_W-1:0] data [2];
        addr[0] = byp_addr_1;
        addr[1] = byp_addr_2;
        for (int p = 0; p < 2; p++) begin
            hit[p]  = 1'b0;
            data[p] = '0;
            if (addr[p] != ADDR_W'(REG_ZERO)) begin
                if (stage_valid_q && stage_req_q.dest == addr[p]) begin
                    hit[p]  = 1'b1;
                    data[p] = stage_req_q.data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (age_valid[i] && age_req[i].dest == addr[p]) begin
                        hit[p]  = 1'b1;
                        data[p] = age_req[i].data;
                    end
                end
            end
        end
        byp_hit_1  = hit[0];
        byp_hit_2  = hit[1];
        byp_data_1 = data[0];
        byp_data_2 = data[1];
    end

    assign rf_regwrite       = stage_valid_q;
    assign rf_write_register = stage_req_q.dest;
    assign rf_write_data     = stage_req_q.data;
    assign busy              = busy_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios followed by random traffic,
// all compared against a queue-based model of pending register writes.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    // Clock / reset and DUT signals
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_data = '0;
    logic        drain_en = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  byp_addr_1 = '0;
    logic [4:0]  byp_addr_2 = '0;
    logic        in_ready;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic        rf_regwrite;
    logic [31:0] busy;
    logic        byp_hit_1, byp_hit_2;
    logic [31:0] byp_data_1, byp_data_2;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_dest           (in_dest),
        .in_data           (in_data),
        .drain_en          (drain_en),
        .flush             (flush),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rf_regwrite       (rf_regwrite),
        .busy              (busy),
        .byp_addr_1        (byp_addr_1),
        .byp_addr_2        (byp_addr_2),
        .byp_hit_1         (byp_hit_1),
        .byp_hit_2         (byp_hit_2),
        .byp_data_1        (byp_data_1),
        .byp_data_2        (byp_data_2)
    );

    // Scoreboard / reference model: queued writes {dest,data}, oldest first,
    // plus the one write being presented to the register file.
    int          checks = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];
    logic        st_v = 1'b0;
    logic [4:0]  st_dest = '0;
    logic [31:0] st_data = '0;
    logic        st_known = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (exp_q[i]) b[exp_q[i][36:32]] = 1'b1;
        if (st_v) b[st_dest] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic void model_byp(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            if (st_v && st_dest == a) begin
                h = 1'b1;
                d = st_data;
            end
            foreach (exp_q[i]) begin
                if (exp_q[i][36:32] == a) begin
                    h = 1'b1;
                    d = exp_q[i][31:0];
                end
            end
        end
    endfunction

    // Driver tasks
    task automatic drive(input logic v, input logic [4:0] dst, input logic [31:0] dat,
                         input logic drn, input logic fl);
        in_valid = v;
        in_dest  = dst;
        in_data  = dat;
        drain_en = drn;
        flush    = fl;
    endtask

    // One clock: check combinational outputs, advance the model, then check
    // registered outputs just after the edge.
    task automatic step();
        logic        h;
        logic [31:0] d;
        logic        acc;
        logic [36:0] head;
        #1;
        check("in_ready", in_ready, (!reset && exp_q.size() < DEPTH) ? 1 : 0);
        model_byp(byp_addr_1, h, d);
        check("byp_hit_1", byp_hit_1, h);
        check("byp_data_1", byp_data_1, d);
        model_byp(byp_addr_2, h, d);
        check("byp_hit_2", byp_hit_2, h);
        check("byp_data_2", byp_data_2, d);

        acc = in_valid && !reset && (exp_q.size() < DEPTH);
        if (reset) begin
            exp_q.delete();
            st_v = 1'b0; st_dest = '0; st_data = '0; st_known = 1'b1;
        end else if (flush) begin
            exp_q.delete();
            st_v = 1'b0; st_known = 1'b0;
        end else begin
            if (exp_q.size() > 0 && drain_en) begin
                head = exp_q.pop_front();
                st_v = 1'b1; st_dest = head[36:32]; st_data = head[31:0]; st_known = 1'b1;
            end else begin
                st_v = 1'b0;
            end
            if (acc && in_dest != 0) exp_q.push_back({in_dest, in_data});
        end

        @(posedge clk);
        #1;
        check("rf_regwrite", rf_regwrite, st_v);
        if (st_known) begin
            check("rf_write_register", rf_write_register, st_dest);
            check("rf_write_data", rf_write_data, st_data);
        end
        check("busy", busy, model_busy());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_regwrite", rf_regwrite, 0);

        // Single write: busy, then register-file strobe, then busy clears
        byp_addr_1 = 5'd8;
        drive(1, 5'd8, 32'hDEADBEEF, 1, 0);
        step();
        drive(0, 5'd0, 32'h0, 1, 0);
        check("t1_busy8_set", busy[8], 1);
        step();
        check("t1_regwrite", rf_regwrite, 1);
        check("t1_reg", rf_write_register, 8);
        check("t1_data", rf_write_data, 32'hDEADBEEF);
        step();
        check("t1_busy8_clear", busy[8], 0);

        // Fill with drain stalled; fifth request is refused; drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(10 + i), $urandom, 0, 0);
            step();
        end
        #1;
        check("t2_full_ready", in_ready, 0);
        drive(0, 5'd0, 32'h0, 1, 0);
        for (int i = 0; i < 6; i++) step();

        // Two writes to r9: bypass returns the newest until both retire
        byp_addr_1 = 5'd9;
        byp_addr_2 = 5'd9;
        drive(1, 5'd9, 32'd1, 0, 0);
        step();
        drive(1, 5'd9, 32'd2, 0, 0);
        step();
        drive(0, 5'd0, 32'h0, 0, 0);
        #1;
        check("t3_hit", byp_hit_1, 1);
        check("t3_data", byp_data_1, 2);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t3_busy9", busy[9], 0);
        #1;
        check("t3_hit_gone", byp_hit_1, 0);

        // Write to r0 is swallowed
        byp_addr_1 = 5'd0;
        drive(1, 5'd0, 32'h1234, 1, 0);
        step();
        drive(0, 5'd0, 32'h0, 1, 0);
        step();
        check("t4_no_write", rf_regwrite, 0);
        check("t4_busy", busy, 0);

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(3 + i), $urandom, 0, 0);
            step();
        end
        drive(1, 5'd6, 32'h66, 1, 1);
        step();
        drive(0, 5'd0, 32'h0, 1, 0);
        check("t5_busy", busy, 0);
        check("t5_regwrite", rf_regwrite, 0);
        step();
        check("t5_no_ghost", rf_regwrite, 0);

        // Reset while draining
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), $urandom, 0, 0);
            step();
        end
        drive(0, 5'd0, 32'h0, 1, 0);
        step();
        reset = 1'b1;
        step();
        check("t6_regwrite", rf_regwrite, 0);
        check("t6_busy", busy, 0);
        check("t6_reg", rf_write_register, 0);
        reset = 1'b0;
        drive(1, 5'd7, 32'h77, 1, 0);
        step();
        drive(0, 5'd0, 32'h0, 1, 0);
        step();
        check("t6_fresh", rf_write_data, 32'h77);
        step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 99) < 4);
            byp_addr_1 = 5'($urandom_range(0, 6));
            byp_addr_2 = 5'($urandom_range(0, 6));
            step();
        end

        reset = 1'b0;
        drive(0, 5'd0, 32'h0, 1, 0);
        for (int i = 0; i < 8; i++) step();
        check("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
